float_to_int: RTL and testbench
===============================

# float_to_int

Pipelined float-to-signed-integer converter. It is the inverse of the integer-to-float path in the float library. It accepts one IEEE-style float (parameterised mantissa/exponent) per enabled clock and produces a truncated, saturated two's-complement integer three enabled cycles later. An exponent offset lets fixpoint results (e.g. Q7.8) come out with no extra multiply. It sits at the float-to-fixpoint boundary, e.g. feeding integer/fixpoint datapaths from float units.

## Interface
Parameters:
- MANTISSA_SIZE, 23, stored mantissa bits (hidden bit excluded)
- EXPONENT_SIZE, 8, exponent field bits; bias = 2^(EXPONENT_SIZE-1)-1
- INT_SIZE, 32, output integer width incl. sign; must be >= 2
- FLOAT_SIZE (local), 1+EXPONENT_SIZE+MANTISSA_SIZE

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; when 0 every pipeline register holds
- offset  in  EXPONENT_SIZE  signed; result = trunc(value * 2^(-offset))
- in  in  FLOAT_SIZE  {sign, exponent, mantissa}
- in_valid  in  1  qualifies `in`/`offset` on an enabled cycle
- out  out  INT_SIZE  signed result
- out_valid  out  1  `out` and `overflow` correspond to an accepted input
- overflow  out  1  result saturated, or input was NaN/Inf

## Operation
- Stage 1 (unpack/classify): E = exp - BIAS - offset, signed, EXPONENT_SIZE+2 bits so it cannot wrap. Classes are checked in this priority:
  - exp all ones: mantissa!=0 is NaN, mantissa==0 is Inf.
  - exp==0 (zero/denormal) gives ZERO.
  - E<0 gives ZERO.
  - E==INT_SIZE-1 with sign=1 and mantissa==0 gives MIN_EXACT.
  - E>=INT_SIZE-1 gives SAT.
  - Otherwise NORMAL.
- Stage 2 (align): significand {1,mantissa}.
  - If E>=MANTISSA_SIZE, shift left by E-MANTISSA_SIZE.
  - Otherwise shift right by MANTISSA_SIZE-E, discarding shifted-out bits (truncate toward zero).
  - Magnitude field is INT_SIZE-1 bits; NORMAL guarantees no loss of high bits.
- Stage 3 (sign/saturate):
  - NORMAL: out = sign ? -mag : mag, overflow=0.
  - ZERO: out=0, overflow=0. Negative inputs give 0, never -0 patterns.
  - MIN_EXACT: out=-2^(INT_SIZE-1), overflow=0.
  - SAT/Inf: out = sign ? -2^(INT_SIZE-1) : 2^(INT_SIZE-1)-1, overflow=1.
  - NaN: out=0, overflow=1.
- Valid bits travel with data. Registers with in_valid=0 still update data (don't-care), but out_valid reports 0.

## Timing
- Latency: 3 enabled (ce=1) cycles from `in` sampled to `out`/`out_valid`/`overflow` updated. Throughput is 1 per enabled cycle.
- ce=0: all stages, including valid bits and outputs, hold their values. There is no bubble insertion and no loss.
- reset=1 at a rising edge clears all stage valids, out_valid=0, out=0, overflow=0, regardless of ce (reset has priority over ce).
- Reset mid-flight discards all in-flight conversions. The first input accepted on the cycle after reset deasserts appears 3 enabled cycles later.
- No backpressure; the consumer controls flow via ce.
- Simultaneous reset and in_valid: the input is dropped.

## Structure
- The shared float package/header holds:
  - FLOAT_SIZE and EXPONENT_BIAS derivation;
  - the sign/exponent/mantissa field position constants;
  - the class encoding (ZERO, NORMAL, MIN_EXACT, SAT, INF, NAN; 3 bits).
- These constants are shared with the int-to-float and arithmetic blocks.
- One sub-module, `mantissa_align`: a combinational bidirectional barrel shift of the significand to the INT_SIZE-1 magnitude, given signed E. It is instantiated between the stage 1 and stage 2 registers.
- The top level holds the three register stages, the valid pipeline and the saturation mux.

## Test plan
All cases use default parameters, ce=1 and offset 0 unless stated.
- 1.5 (0x3FC00000) gives out=1, overflow=0, out_valid high exactly 3 cycles after in_valid; -2.75 (0xC0300000) gives 0xFFFFFFFE.
- 1.5 with offset=0xF8 (-8) gives 384 (0x00000180); 384.0 (0x43C00000) with offset=0x08 gives 1.
- 3.0e9 (0x4F32D05E) gives 0x7FFFFFFF, overflow=1; -2^31 (0xCF000000) gives 0x80000000, overflow=0; -Inf (0xFF800000) gives 0x80000000, overflow=1.
- 0.75 (0x3F400000) gives 0, denormal 0x00000001 gives 0, -0.5 (0xBF000000) gives 0, all with overflow=0; NaN (0x7FC00000) gives 0 with overflow=1.
- Back-to-back stream 1.0, 2.0, 3.0, 4.0 with ce low for 2 cycles mid-stream gives outputs 1, 2, 3, 4 in order. Outputs are unchanged during ce=0, and each output arrives 3 enabled cycles after its input.
- Reset pulsed with 3 conversions in flight gives out_valid=0, out=0, overflow=0 on the following cycle, and no stale results afterwards. A new input after reset emerges after 3 cycles.

Source files
------------

// File: rtl/float_to_int_pkg.sv
// float_to_int_pkg: float layout constants and value classes shared by the float blocks
package float_to_int_pkg;

    localparam int DEFAULT_MANTISSA_SIZE = 23;
    localparam int DEFAULT_EXPONENT_SIZE = 8;
    localparam int DEFAULT_INT_SIZE      = 32;

    // classification decided in stage 1 and carried down the pipeline
    typedef enum logic [2:0] {
        CLS_ZERO      = 3'd0,
        CLS_NORMAL    = 3'd1,
        CLS_MIN_EXACT = 3'd2,
        CLS_SAT       = 3'd3,
        CLS_INF       = 3'd4,
        CLS_NAN       = 3'd5
    } float_class_t;

    function automatic int float_size(input int mantissa_size, input int exponent_size);
        return 1 + exponent_size + mantissa_size;
    endfunction

    function automatic int exponent_bias(input int exponent_size);
        return (1 << (exponent_size - 1)) - 1;
    endfunction

    // sign sits above the exponent, which sits above the mantissa
    function automatic int sign_pos(input int mantissa_size, input int exponent_size);
        return mantissa_size + exponent_size;
    endfunction

    function automatic int exponent_lsb(input int mantissa_size);
        return mantissa_size;
    endfunction

endpackage

// File: rtl/float_to_int_mantissa_align.sv
// mantissa_align: bidirectional barrel shift of the significand to the integer magnitude
module mantissa_align #(
    parameter int MANTISSA_SIZE = 23,
    parameter int E_WIDTH       = 10,
    parameter int INT_SIZE      = 32
) (
    input  logic [MANTISSA_SIZE:0]      significand,
    input  logic signed [E_WIDTH-1:0]   e,
    output logic [INT_SIZE-2:0]         mag
);

    localparam int W = MANTISSA_SIZE + INT_SIZE;

    logic [W-1:0] wide;
    logic [W-1:0] shifted;
    int           e_i;

    // left shift when the binary point lies past the mantissa, otherwise truncate right
    always_comb begin
        e_i     = int'(e);
        wide    = W'(significand);
        shifted = e_i >= MANTISSA_SIZE ? wide << (e_i - MANTISSA_SIZE)
                                       : wide >> (MANTISSA_SIZE - e_i);
        mag     = shifted[INT_SIZE-2:0];
    end

endmodule

// File: rtl/float_to_int.sv
// float_to_int: 3-stage pipelined float to truncated, saturated signed integer
module float_to_int
    import float_to_int_pkg::*;
#(
    parameter  int MANTISSA_SIZE = DEFAULT_MANTISSA_SIZE,
    parameter  int EXPONENT_SIZE = DEFAULT_EXPONENT_SIZE,
    parameter  int INT_SIZE      = DEFAULT_INT_SIZE,
    localparam int FLOAT_SIZE    = float_size(MANTISSA_SIZE, EXPONENT_SIZE)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ce,
    input  logic signed [EXPONENT_SIZE-1:0] offset,
    input  logic [FLOAT_SIZE-1:0]           in,
    input  logic                            in_valid,
    output logic [INT_SIZE-1:0]             out,
    output logic                            out_valid,
    output logic                            overflow
);

    localparam int EW       = EXPONENT_SIZE + 2;
    localparam int BIAS     = exponent_bias(EXPONENT_SIZE);
    localparam int SIGN_POS = sign_pos(MANTISSA_SIZE, EXPONENT_SIZE);
    localparam int EXP_LSB  = exponent_lsb(MANTISSA_SIZE);
    localparam logic [INT_SIZE-1:0] INT_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};
    localparam logic [INT_SIZE-1:0] INT_MAX = ~INT_MIN;

    logic                     sign_in;
    logic [EXPONENT_SIZE-1:0] exp_in;
    logic [MANTISSA_SIZE-1:0] man_in;
    logic signed [EW-1:0]     e_in;
    float_class_t             cls_in;

    logic                     s1_valid;
    logic                     s1_sign;
    logic signed [EW-1:0]     s1_e;
    logic [MANTISSA_SIZE-1:0] s1_man;
    float_class_t             s1_cls;

    logic [INT_SIZE-2:0]      align_mag;

    logic                     s2_valid;
    logic                     s2_sign;
    logic [INT_SIZE-2:0]      s2_mag;
    float_class_t             s2_cls;

    logic [INT_SIZE-1:0]      mag_ext;
    logic [INT_SIZE-1:0]      result;
    logic                     result_ovf;

    assign sign_in = in[SIGN_POS];
    assign exp_in  = in[EXP_LSB +: EXPONENT_SIZE];
    assign man_in  = in[MANTISSA_SIZE-1:0];

    // unbiased exponent minus offset, two bits wider so it never wraps
    assign e_in = $signed({2'b00, exp_in}) - EW'(BIAS) - EW'(offset);

    // classify in priority order: special, zero/denormal, underflow, exact min, saturate
    always_comb begin
        cls_in = &exp_in ? (|man_in ? CLS_NAN : CLS_INF)
               : exp_in == '0 ? CLS_ZERO
               : e_in < 0 ? CLS_ZERO
               : (int'(e_in) == INT_SIZE - 1 && sign_in && man_in == '0) ? CLS_MIN_EXACT
               : int'(e_in) >= INT_SIZE - 1 ? CLS_SAT
               : CLS_NORMAL;
    end

    // stage 1: register unpacked fields and class
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (ce) begin
            s1_valid <= in_valid;
            s1_sign  <= sign_in;
            s1_e     <= e_in;
            s1_man   <= man_in;
            s1_cls   <= cls_in;
        end
    end

    mantissa_align #(
        .MANTISSA_SIZE (MANTISSA_SIZE),
        .E_WIDTH       (EW),
        .INT_SIZE      (INT_SIZE)
    ) u_align (
        .significand ({1'b1, s1_man}),
        .e           (s1_e),
        .mag         (align_mag)
    );

    // stage 2: register aligned magnitude
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else if (ce) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_mag   <= align_mag;
            s2_cls   <= s1_cls;
        end
    end

    assign mag_ext = {1'b0, s2_mag};

    // apply sign, saturate, or force special results
    always_comb begin
        result = s2_cls == CLS_NORMAL ? (s2_sign ? -mag_ext : mag_ext)
               : s2_cls == CLS_MIN_EXACT ? INT_MIN
               : (s2_cls == CLS_SAT || s2_cls == CLS_INF) ? (s2_sign ? INT_MIN : INT_MAX)
               : '0;
        result_ovf = s2_cls == CLS_SAT || s2_cls == CLS_INF || s2_cls == CLS_NAN;
    end

    // stage 3: registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            overflow  <= 1'b0;
        end else if (ce) begin
            out_valid <= s2_valid;
            out       <= result;
            overflow  <= result_ovf;
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: directed self-checking bench for float_to_int
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic [7:0]  offset = 8'h00;
    logic [31:0] in_f = 32'h0;
    logic        in_valid = 1'b0;
    logic [31:0] out;
    logic        out_valid;
    logic        overflow;

    int total = 0;
    int bad = 0;

    float_to_int dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .offset    (offset),
        .in        (in_f),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // drive one input and wait (bounded) for its result; lat counts enabled edges
    task automatic run_one(input logic [31:0] f, input logic [7:0] off,
                           output logic [31:0] o, output logic ov, output int lat);
        in_f = f;
        offset = off;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        offset = 8'h00;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        o = out;
        ov = overflow;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=00000000", out); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        reset = 1'b0;
        ce = 1'b1;
        @(posedge clk); #1;
    endtask

    // table of {input, offset, expected out, expected overflow}; each checked for latency too
    task automatic check_vectors(input string name, input int n,
                                 input logic [31:0] f[8], input logic [7:0] off[8],
                                 input logic [31:0] eo[8], input logic ev[8]);
        logic [31:0] o;
        logic        ov;
        int          lat;
        for (int i = 0; i < n; i++) begin
            run_one(f[i], off[i], o, ov, lat);
            total++; if (lat !== 3) begin bad++; $display("FAIL %s_lat[%0d] got=%0d want=3", name, i, lat); end
            total++; if (o !== eo[i]) begin bad++; $display("FAIL %s_out[%0d] got=%h want=%h", name, i, o, eo[i]); end
            total++; if (ov !== ev[i]) begin bad++; $display("FAIL %s_ovf[%0d] got=%b want=%b", name, i, ov, ev[i]); end
        end
    endtask

    task automatic test_basic;
        check_vectors("basic", 2,
            '{32'h3FC00000, 32'hC0300000, 0, 0, 0, 0, 0, 0},
            '{8'h00, 8'h00, 0, 0, 0, 0, 0, 0},
            '{32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 0},
            '{1'b0, 1'b0, 0, 0, 0, 0, 0, 0});
    endtask

    task automatic test_offset;
        check_vectors("offset", 2,
            '{32'h3FC00000, 32'h43C00000, 0, 0, 0, 0, 0, 0},
            '{8'hF8, 8'h08, 0, 0, 0, 0, 0, 0},
            '{32'h00000180, 32'h00000001, 0, 0, 0, 0, 0, 0},
            '{1'b0, 1'b0, 0, 0, 0, 0, 0, 0});
    endtask

    task automatic test_saturate;
        check_vectors("sat", 4,
            '{32'h4F32D05E, 32'hCF000000, 32'hFF800000, 32'h7F800000, 0, 0, 0, 0},
            '{8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0},
            '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 0},
            '{1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0});
    endtask

    task automatic test_zero_nan;
        check_vectors("zero", 4,
            '{32'h3F400000, 32'h00000001, 32'hBF000000, 32'h7FC00000, 0, 0, 0, 0},
            '{8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0},
            '{32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0});
    endtask

    // stream 1.0..4.0 with a 2-cycle ce stall while result 1 is on the output
    task automatic test_back_to_back;
        logic [31:0] fin [9] = '{32'h3F800000, 32'h40000000, 32'h40400000, 0, 0,
                                 32'h40800000, 0, 0, 0};
        logic        c_ce[9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
        logic        c_v [9] = '{1, 1, 1, 0, 0, 1, 0, 0, 0};
        logic        e_v [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic [31:0] e_o [9] = '{0, 0, 1, 1, 1, 2, 3, 4, 0};
        for (int i = 0; i < 9; i++) begin
            ce = c_ce[i];
            in_valid = c_v[i];
            in_f = fin[i];
            @(posedge clk); #1;
            total++; if (out_valid !== e_v[i]) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=%b", i, out_valid, e_v[i]); end
            if (e_v[i]) begin
                total++; if (out !== e_o[i]) begin bad++; $display("FAIL b2b_out[%0d] got=%h want=%h", i, out, e_o[i]); end
            end
        end
        ce = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_in_flight;
        logic [31:0] o;
        logic        ov;
        int          lat;
        in_valid = 1'b1;
        in_f = 32'h40A00000;
        @(posedge clk); #1;
        in_f = 32'h40C00000;
        @(posedge clk); #1;
        in_f = 32'h40E00000;
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flight_valid got=%b want=0", out_valid); end
        total++; if (out !== 32'h0) begin bad++; $display("FAIL flight_out got=%h want=00000000", out); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flight_ovf got=%b want=0", overflow); end
        reset = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flight_stale[%0d] got=%b want=0", i, out_valid); end
        end
        run_one(32'h41000000, 8'h00, o, ov, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL after_reset_lat got=%0d want=3", lat); end
        total++; if (o !== 32'h00000008) begin bad++; $display("FAIL after_reset_out got=%h want=00000008", o); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL after_reset_ovf got=%b want=0", ov); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset();
        test_saturate();
        test_zero_nan();
        test_back_to_back();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
